// File: rtl/alu_share_arb.sv
// ============================================================================
//  Module      : alu_share_arb
//  Description : One combinational 32-bit ALU shared by NREQ requesters.
//                A round-robin arbiter picks one request per cycle. The
//                result lands in a single output register with valid/ready
//                backpressure and is tagged with the issuing requester index.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NREQ        number of requesters (2..4)
//    IDW         requester tag width, derived as $clog2(NREQ)
//  Ports
//    clk         rising-edge clock
//    rst_n       synchronous active-low reset
//    req_valid   [NREQ]     requester i presents an operation
//    req_ready   [NREQ]     requester i's operation is accepted this cycle
//    req_a       [NREQ*32]  operand A, slice i = [32i+31:32i]
//    req_b       [NREQ*32]  operand B, same packing
//    req_op      [NREQ*4]   opcode, slice i = [4i+3:4i]
//    rsp_valid   result register holds an unconsumed result
//    rsp_ready   consumer accepts the result this cycle
//    rsp_o       [32]       ALU result
//    rsp_id      [IDW]      index of the issuing requester
//    rsp_illegal issued opcode was 11..15 (rsp_o is 0 then)
//  Build option
//    ALU_ARB_FIXED_PRIO_EN  defined: fixed priority, lowest index wins.
//                           undefined: round-robin starting after `last`.
// ============================================================================
`default_nettype none

module alu_share_arb #(
    parameter  int NREQ = 2,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ*4-1:0]    req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_o,
    output logic [IDW-1:0]       rsp_id,
    output logic                 rsp_illegal
);

    localparam logic [3:0] c_op_add  = 4'd0;
    localparam logic [3:0] c_op_sub  = 4'd1;
    localparam logic [3:0] c_op_sra  = 4'd2;
    localparam logic [3:0] c_op_srl  = 4'd3;
    localparam logic [3:0] c_op_sll  = 4'd4;
    localparam logic [3:0] c_op_and  = 4'd5;
    localparam logic [3:0] c_op_or   = 4'd6;
    localparam logic [3:0] c_op_xor  = 4'd7;
    localparam logic [3:0] c_op_slt  = 4'd8;
    localparam logic [3:0] c_op_sltu = 4'd9;
    localparam logic [3:0] c_op_pass = 4'd10;

    logic            r_valid;
    logic [31:0]     r_res;
    logic [IDW-1:0]  r_id;
    logic            r_ill;
    logic [IDW-1:0]  r_last;

    logic [IDW-1:0]  w_grant;
    logic            w_any;
    logic            w_can_issue;
    logic            w_xfer;
    logic [31:0]     w_a;
    logic [31:0]     w_b;
    logic [3:0]      w_op;
    logic [31:0]     w_res;
    logic            w_big_shamt;

    // ------------------------------------------------------------------
    // Arbiter
    // ------------------------------------------------------------------
`ifdef ALU_ARB_FIXED_PRIO_EN
    // Scan from the top down so the lowest set index is assigned last.
    always_comb begin
        w_grant = '0;
        w_any   = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_grant = IDW'(i);
                w_any   = 1'b1;
            end
        end
    end
`else
    // Each valid requester gets a distance from the slot after `last`;
    // the smallest distance wins, which is the first hit of a wrapping
    // scan starting at last+1.
    always_comb begin
        int w_dist;
        int w_best;
        w_grant = '0;
        w_any   = 1'b0;
        w_dist  = 0;
        w_best  = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i]) begin
                w_dist = (i + 2 * NREQ - 1 - int'(r_last)) % NREQ;
                if (w_dist < w_best) begin
                    w_best  = w_dist;
                    w_grant = IDW'(i);
                    w_any   = 1'b1;
                end
            end
        end
    end
`endif

    assign w_can_issue = !r_valid || rsp_ready;
    // rst_n gates the handshake so no request is acknowledged in reset.
    assign w_xfer      = rst_n && w_any && w_can_issue;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = w_xfer && (w_grant == IDW'(i));
        end
    end

    // ------------------------------------------------------------------
    // Operand select and shared ALU
    // ------------------------------------------------------------------
    always_comb begin
        w_a  = '0;
        w_b  = '0;
        w_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant == IDW'(i)) begin
                w_a  = req_a[32*i +: 32];
                w_b  = req_b[32*i +: 32];
                w_op = req_op[4*i +: 4];
            end
        end
    end

    // The shift amount is the whole of b; anything >= 32 saturates.
    assign w_big_shamt = |w_b[31:5];

    always_comb begin
        w_res = '0;
        case (w_op)
            c_op_add:  w_res = w_a + w_b;
            c_op_sub:  w_res = w_a + ~w_b + 32'd1;
            c_op_sra:  w_res = w_big_shamt ? {32{w_a[31]}}
                                           : 32'($signed(w_a) >>> w_b[4:0]);
            c_op_srl:  w_res = w_big_shamt ? 32'd0 : (w_a >> w_b[4:0]);
            c_op_sll:  w_res = w_big_shamt ? 32'd0 : (w_a << w_b[4:0]);
            c_op_and:  w_res = w_a & w_b;
            c_op_or:   w_res = w_a | w_b;
            c_op_xor:  w_res = w_a ^ w_b;
            c_op_slt:  w_res = {31'd0, $signed(w_a) < $signed(w_b)};
            c_op_sltu: w_res = {31'd0, w_a < w_b};
            c_op_pass: w_res = w_b;
            default:   w_res = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Result register and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_res   <= '0;
            r_id    <= '0;
            r_ill   <= 1'b0;
            r_last  <= IDW'(NREQ - 1);
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_res   <= w_res;
            r_id    <= w_grant;
            r_ill   <= (w_op > c_op_pass);
            r_last  <= w_grant;
        end else if (rsp_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign rsp_valid   = r_valid;
    assign rsp_o       = r_res;
    assign rsp_id      = r_id;
    assign rsp_illegal = r_ill;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arb.sv
// ============================================================================
//  Module      : tb_alu_share_arb
//  Description : Directed self-checking bench for alu_share_arb. One
//                instance with NREQ=2 carries most scenarios; a second with
//                NREQ=3 checks rotation past a requester with valid low.
//                Expected results are queued when stimulus is driven and
//                popped when the DUT presents the result.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_share_arb;

    typedef struct {
        logic [31:0] res;
        logic [1:0]  id;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    // NREQ = 2 instance
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [7:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_o;
    logic [0:0]  rsp_id;
    logic        rsp_illegal;

    // NREQ = 3 instance
    logic [2:0]  v3;
    logic [2:0]  rdy3;
    logic [95:0] a3;
    logic [95:0] b3;
    logic [11:0] op3;
    logic        rv3;
    logic        rr3;
    logic [31:0] o3;
    logic [1:0]  id3;
    logic        ill3;

    alu_share_arb #(.NREQ(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_o(rsp_o), .rsp_id(rsp_id), .rsp_illegal(rsp_illegal)
    );

    alu_share_arb #(.NREQ(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v3), .req_ready(rdy3),
        .req_a(a3), .req_b(b3), .req_op(op3),
        .rsp_valid(rv3), .rsp_ready(rr3),
        .rsp_o(o3), .rsp_id(id3), .rsp_illegal(ill3)
    );

    int passed = 0;
    int total  = 0;

    exp_t sb2[$];
    exp_t sb3[$];
    exp_t m_hold;
    logic m_valid;
    int   m_last;
    int   m3_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Reference grant: wrapping scan starting right after the last grant.
    function automatic int model_grant(input logic [3:0] v, input int last, input int n);
`ifdef ALU_ARB_FIXED_PRIO_EN
        for (int i = 0; i < n; i++)
            if (v[i]) return i;
`else
        for (int k = 1; k <= n; k++) begin
            int idx;
            idx = (last + k) % n;
            if (v[idx]) return idx;
        end
`endif
        return -1;
    endfunction

    function automatic logic [31:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op);
        logic signed [31:0] sa;
        sa = a;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return (b > 32'd31) ? (a[31] ? 32'hFFFF_FFFF : 32'd0) : 32'(sa >>> b);
            4'd3:  return (b > 32'd31) ? 32'd0 : a >> b;
            4'd4:  return (b > 32'd31) ? 32'd0 : a << b;
            4'd5:  return a & b;
            4'd6:  return a | b;
            4'd7:  return a ^ b;
            4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    // One cycle on the NREQ=2 instance.
    task automatic step2(input logic rstv, input logic [1:0] v,
                         input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                         input logic rr);
        int   g;
        logic xfer;
        logic [1:0] er;
        exp_t e;
        @(negedge clk);
        rst_n     = rstv;
        req_valid = v;
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        req_op    = {op1, op0};
        rsp_ready = rr;
        #1;
        g    = model_grant({2'b00, v}, m_last, 2);
        xfer = rstv && (!m_valid || rr) && (g >= 0);
        er   = xfer ? ((g == 0) ? 2'b01 : 2'b10) : 2'b00;
        chk("req_ready", 32'(req_ready), 32'(er));
        if (!rstv) begin
            m_valid = 1'b0;
            m_last  = 1;
            m_hold  = '{res: 32'd0, id: 2'd0, ill: 1'b0};
            sb2.delete();
        end else if (xfer) begin
            e.res = (g == 0) ? model_alu(a0, b0, op0) : model_alu(a1, b1, op1);
            e.id  = 2'(g);
            e.ill = ((g == 0) ? op0 : op1) > 4'd10;
            sb2.push_back(e);
            m_last  = g;
            m_valid = 1'b1;
        end else if (rr) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        if (xfer) m_hold = sb2.pop_front();
        chk("rsp_o", rsp_o, m_hold.res);
        chk("rsp_id", 32'(rsp_id), 32'(m_hold.id));
        chk("rsp_illegal", 32'(rsp_illegal), 32'(m_hold.ill));
    endtask

    // One cycle on the NREQ=3 instance, consumer always ready.
    task automatic step3(input logic [2:0] v);
        int   g;
        logic [2:0] er;
        exp_t e;
        exp_t got;
        @(negedge clk);
        v3  = v;
        rr3 = 1'b1;
        #1;
        g  = model_grant({1'b0, v}, m3_last, 3);
        er = (g >= 0) ? 3'(1 << g) : 3'b000;
        chk("req_ready3", 32'(rdy3), 32'(er));
        if (g >= 0) begin
            e.res = model_alu(32'(g + 1), 32'd100, 4'd0);
            e.id  = 2'(g);
            e.ill = 1'b0;
            sb3.push_back(e);
            m3_last = g;
        end
        @(posedge clk);
        #1;
        chk("rsp_valid3", 32'(rv3), 32'(g >= 0));
        if (g >= 0) begin
            got = sb3.pop_front();
            chk("rsp_id3", 32'(id3), 32'(got.id));
            chk("rsp_o3", o3, got.res);
        end
    endtask

    logic [3:0]  t_op [14];
    logic [31:0] t_a  [14];
    logic [31:0] t_b  [14];
    int          cseq [4];
    int          hold_o;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
        v3 = '0; a3 = {32'd3, 32'd2, 32'd1}; b3 = {3{32'd100}}; op3 = '0; rr3 = 1'b1;
        m_valid = 1'b0; m_last = 1; m3_last = 2;
        m_hold = '{res: 32'd0, id: 2'd0, ill: 1'b0};

`ifdef ALU_ARB_FIXED_PRIO_EN
        cseq = '{0, 0, 0, 0};
`else
        cseq = '{0, 1, 0, 1};
`endif
        t_op = '{4'd1, 4'd2, 4'd3, 4'd9, 4'd8, 4'd12, 4'd4, 4'd2,
                 4'd3, 4'd5, 4'd6, 4'd7, 4'd10, 4'd4};
        t_a  = '{32'd5, 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd1, 32'd7, 32'd1, 32'h8000_0000,
                 32'hFFFF_FFFF, 32'h0000_F0F0, 32'h0000_F0F0, 32'h0000_F0F0, 32'd0, 32'd1};
        t_b  = '{32'd3, 32'd4, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd31, 32'd32,
                 32'd40, 32'h0000_FF00, 32'h0000_FF00, 32'h0000_FF00, 32'hDEAD_BEEF, 32'd32};

        // Reset with both requesters asserting: nothing may be accepted.
        step2(1'b0, 2'b11, 4'd0, 32'd1, 32'd1, 4'd0, 32'd2, 32'd2, 1'b1);
        step2(1'b0, 2'b11, 4'd0, 32'd1, 32'd1, 4'd0, 32'd2, 32'd2, 1'b1);

        // Single add on requester 0.
        step2(1'b1, 2'b01, 4'd0, 32'd5, 32'd3, 4'd0, 32'd0, 32'd0, 1'b1);
        chk("add_result", rsp_o, 32'd8);

        // Per-op sweep on requester 1.
        for (int i = 0; i < 14; i++)
            step2(1'b1, 2'b10, 4'd0, 32'd0, 32'd0, t_op[i], t_a[i], t_b[i], 1'b1);
        step2(1'b1, 2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 1'b1);

        // Contention from a fresh reset.
        step2(1'b0, 2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step2(1'b1, 2'b11, 4'd0, 32'(10 + i), 32'd1, 4'd1, 32'(20 + i), 32'd1, 1'b1);
            chk("contend_id", 32'(rsp_id), 32'(cseq[i]));
        end

        // Backpressure: result held for three cycles, then released.
        step2(1'b1, 2'b01, 4'd6, 32'h00AA_0000, 32'h0000_0055, 4'd0, 32'd0, 32'd0, 1'b1);
        hold_o = int'(rsp_o);
        for (int i = 0; i < 3; i++) begin
            step2(1'b1, 2'b11, 4'd0, 32'd1, 32'd2, 4'd7, 32'd3, 32'd4, 1'b0);
            chk("stall_hold", rsp_o, 32'(hold_o));
        end
        step2(1'b1, 2'b11, 4'd0, 32'd1, 32'd2, 4'd7, 32'd3, 32'd4, 1'b1);

        // Reset while a result is held, then both valid after release.
        step2(1'b1, 2'b10, 4'd0, 32'd0, 32'd0, 4'd0, 32'd9, 32'd9, 1'b0);
        step2(1'b0, 2'b11, 4'd0, 32'd1, 32'd1, 4'd0, 32'd2, 32'd2, 1'b0);
        step2(1'b1, 2'b11, 4'd0, 32'd1, 32'd1, 4'd0, 32'd2, 32'd2, 1'b1);
        chk("post_reset_first_id", 32'(rsp_id), 32'd0);
        step2(1'b1, 2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 1'b1);

        // NREQ = 3 with requester 1 idle.
        for (int i = 0; i < 4; i++) step3(3'b101);
        step3(3'b000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_share_arb.md
# alu_share_arb

Shares one combinational 32-bit ALU between `NREQ` requesters in the 3-stage pipeline, e.g. the execute stage plus a branch/address-generation port. A round-robin arbiter grants one request per cycle and drives the ALU. Each result is held in a single output register with valid/ready backpressure, tagged with the index of the requester that issued it.

## Interface
- `NREQ`, 2, number of requesters; legal 2..4
- `IDW`, `$clog2(NREQ)`, width of the requester tag; derived, not overridden
- `clk`  in  1  clock; rising-edge
- `rst_n`  in  1  reset; synchronous, active-low
- `req_valid`  in  NREQ  bit i set when requester i presents an operation
- `req_ready`  out  NREQ  bit i set when requester i's operation is accepted this cycle
- `req_a`  in  NREQ*32  operand A; slice i = bits [32i+31:32i]
- `req_b`  in  NREQ*32  operand B; same packing as `req_a`
- `req_op`  in  NREQ*4  ALU opcode; slice i = bits [4i+3:4i]
- `rsp_valid`  out  1  result register holds an unconsumed result
- `rsp_ready`  in  1  consumer accepts the result this cycle
- `rsp_o`  out  32  ALU result
- `rsp_id`  out  IDW  index of the requester that issued the result
- `rsp_illegal`  out  1  issued opcode was 11..15; `rsp_o` is 0 in that case

## Operation
- Opcode map:
  - 0 add, 1 sub (a + ~b + 1)
  - 2 arithmetic shift right, 3 logical shift right, 4 shift left
  - 5 and, 6 or, 7 xor
  - 8 signed less-than, 9 unsigned less-than; result 0/1
  - 10 pass b
  - 11..15 result 0
- Shift amount is the full 32-bit b; shifts by 32 or more give 0 (sra: all sign bits).
- `can_issue = !rsp_valid || rsp_ready`.
- Grant: scan from `(last+1) mod NREQ` upward, wrapping; the first set `req_valid` bit wins.
- `req_ready[g] = can_issue` for the granted index g only; all other bits are 0. With no `req_valid` set, `req_ready` is all 0.
- `req_ready` depends combinationally on `req_valid` and `rsp_ready`. Requesters must not make `valid` depend on `ready`.
- Transfer happens when `req_valid[g] && req_ready[g]`. On a transfer:
  - capture ALU(a_g, b_g, op_g) into `rsp_o`
  - set `rsp_id = g`, `rsp_illegal = (op_g > 10)`, `rsp_valid = 1`
  - set `last = g`
- Without a transfer:
  - `rsp_ready && rsp_valid` clears `rsp_valid`.
  - `rsp_o`, `rsp_id` and `rsp_illegal` hold their values.
  - `last` is unchanged.
- Simultaneous consume and issue in one cycle: the new result replaces the old and `rsp_valid` stays 1.
- Stall (`rsp_valid && !rsp_ready`): `req_ready` is all 0, the output registers are frozen, and `last` is frozen.
- Fairness: a requester holding `req_valid` is granted within NREQ transfers.

## Timing
- Reset values on the first edge with `rst_n` = 0:
  - `rsp_valid` = 0, `rsp_o` = 0, `rsp_id` = 0, `rsp_illegal` = 0
  - `last` = NREQ-1, so requester 0 has first priority
- `req_ready` is 0 throughout reset.
- Reset asserted mid-operation discards any held result. Nothing is replayed.
- Latency: the result is visible one cycle after the accepting edge.
- Throughput: one result per cycle while `rsp_ready` stays at 1.
- No combinational path from `req_a`, `req_b` or `req_op` to any output.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`
- Defined: fixed priority, the lowest index wins. `last` still exists but does not affect the grant. Fairness is not guaranteed.
- Undefined (default): round-robin as described in Operation.

## Test plan
- Single add: requester 0 issues a=5, b=3, op=0 with `rsp_ready` = 1.
  - Next cycle: `rsp_valid` = 1, `rsp_o` = 8, `rsp_id` = 0, `rsp_illegal` = 0.
- Per-op check on requester 1:
  - sub 5-3 → 2
  - sra 0x80000000 by 4 → 0xF8000000
  - srl 0x80000000 by 4 → 0x08000000
  - sltu 1 vs 0xFFFFFFFF → 1
  - slt 1 vs 0xFFFFFFFF → 0
  - op 12 → 0 with `rsp_illegal` = 1
- Contention, NREQ = 2, both requesters valid for 4 cycles, `rsp_ready` = 1:
  - round-robin build: grants 0, 1, 0, 1; `rsp_id` follows one cycle later
  - with `ALU_ARB_FIXED_PRIO_EN` defined: grants 0, 0, 0, 0
- Backpressure: hold `rsp_ready` = 0 for 3 cycles with a result held.
  - `req_ready` stays 00 and `rsp_o` is stable.
  - On the cycle `rsp_ready` returns to 1, the next grant is accepted and `rsp_valid` stays 1.
- Reset mid-stream: assert `rst_n` = 0 while `rsp_valid` = 1.
  - Next edge: `rsp_valid` = 0, `rsp_o` = 0.
  - After release with both requesters valid, the first grant goes to requester 0.
- NREQ = 3, valid pattern 101 held, `rsp_ready` = 1:
  - grants 0, 2, 0, 2; requester 1 is never granted while its valid is low.
